cwalk_ctrl: RTL and testbench

Parametrised pedestrian-crossing controller, successor to the fixed 40-tick crosswalk sequencer.
- Sequences WALK, FLASH (blinking hand with countdown) and DONT (steady hand) phases.
- Phase lengths are set by parameters, and time advances on an external tick enable.
- New: a pedestrian push-button request path, with a recall mode that selects fixed cycling or on-demand service.
- Drives the walk/hand lamps and the countdown digit display.

---
 rtl/cwalk_pkg.sv | 39 +++
 rtl/cwalk_timer.sv | 37 +++
 rtl/cwalk_ctrl.sv | 124 ++++++++++++
 tb/tb_cwalk_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cwalk_pkg.sv
// Shared types and helpers for the pedestrian-crossing controller.
// Phase encoding is visible on the phase output, so the enum values are fixed.
package cwalk_pkg;

    localparam int unsigned PHASE_W = 2;

    typedef enum logic [PHASE_W-1:0] {
        PH_DONT  = 2'd0,
        PH_WALK  = 2'd1,
        PH_FLASH = 2'd2
    } phase_e;

    // Length in ticks of a phase, given the instance's phase-length parameters.
    function automatic int unsigned phase_len(
        input phase_e      ph,
        input int unsigned walk_t,
        input int unsigned flash_t,
        input int unsigned dont_t
    );
        case (ph)
            PH_WALK:  return walk_t;
            PH_FLASH: return flash_t;
            default:  return dont_t;
        endcase
    endfunction

    function automatic int unsigned max3(
        input int unsigned a,
        input int unsigned b,
        input int unsigned c
    );
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/cwalk_timer.sv
// Phase elapsed-tick counter. Wraps to zero at the end of a phase unless told
// to hold, in which case it parks at len-1 so done keeps firing on each tick.
module cwalk_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic [CNT_W:0]   len,
    input  logic             hold,
    output logic [CNT_W-1:0] el,
    output logic             done
);

    localparam int unsigned LEN_W = CNT_W + 1;

    logic [CNT_W-1:0] r_el;
    logic             w_last;

    assign w_last = ({1'b0, r_el} == (len - LEN_W'(1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_el <= '0;
        end else if (tick) begin
            if (!w_last) begin
                r_el <= r_el + CNT_W'(1);
            end else if (!hold) begin
                r_el <= '0;
            end
        end
    end

    assign el   = r_el;
    assign done = tick & w_last;

endmodule

// File: rtl/cwalk_ctrl.sv
// Pedestrian-crossing controller: WALK -> FLASH -> DONT sequencing on an external
// tick, with push-button request latching and a recall (free-running) mode.
module cwalk_ctrl
    import cwalk_pkg::*;
#(
    parameter int unsigned WALK_T  = 8,
    parameter int unsigned FLASH_T = 16,
    parameter int unsigned DONT_T  = 16,
    parameter int unsigned NUM_W   = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             recall,
    input  logic             ped_req,
    output logic             walk,
    output logic             hand,
    output logic             num_on,
    output logic [NUM_W-1:0] num,
    output logic             req_pend,
    output logic [1:0]       phase
);

    localparam int unsigned LEN_W   = CNT_W + 1;
    localparam int unsigned HALF_FL = FLASH_T / 2;
    localparam int unsigned MAX_LEN = max3(WALK_T, FLASH_T, DONT_T);

    localparam bit LEGAL =
        (WALK_T >= 1) && (DONT_T >= 1) && (FLASH_T >= 2) && ((FLASH_T % 2) == 0) &&
        (CNT_W >= 1) && (CNT_W <= 31) && (NUM_W >= 1) && (NUM_W <= 31) &&
        (longint'(HALF_FL) <= ((longint'(1) << NUM_W) - longint'(1))) &&
        (longint'(MAX_LEN) <= (longint'(1) << CNT_W));

    if (!LEGAL) begin : g_param_err
        $fatal(1, "cwalk_ctrl: illegal parameter set");
    end

    phase_e           r_phase;
    phase_e           w_phase_nxt;
    logic             r_pend;
    logic             w_pend_nxt;
    logic [CNT_W-1:0] w_el;
    logic             w_done;
    logic             w_go;
    logic             w_hold;
    logic             w_enter_walk;
    logic [LEN_W-1:0] w_len;

    assign w_len  = LEN_W'(phase_len(r_phase, WALK_T, FLASH_T, DONT_T));
    assign w_go   = recall | r_pend | ped_req;
    // With no reason to cross, DONT parks at its last tick waiting for one.
    assign w_hold = (r_phase == PH_DONT) & ~w_go;

    cwalk_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .len   (w_len),
        .hold  (w_hold),
        .el    (w_el),
        .done  (w_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase <= PH_DONT;
            r_pend  <= 1'b0;
        end else begin
            r_phase <= w_phase_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

    // Next phase and request flag; entering WALK consumes any pending request.
    always_comb begin
        w_phase_nxt  = r_phase;
        w_pend_nxt   = r_pend;
        w_enter_walk = 1'b0;
        if (w_done) begin
            case (r_phase)
                PH_WALK:  w_phase_nxt = PH_FLASH;
                PH_FLASH: w_phase_nxt = PH_DONT;
                default: begin
                    if (w_go) begin
                        w_phase_nxt  = PH_WALK;
                        w_enter_walk = 1'b1;
                    end
                end
            endcase
        end
        if (w_enter_walk) begin
            w_pend_nxt = 1'b0;
        end else if (ped_req && (r_phase != PH_WALK)) begin
            w_pend_nxt = 1'b1;
        end
    end

    // Lamp and countdown decode straight from the phase and elapsed count.
    always_comb begin
        walk   = 1'b0;
        hand   = 1'b1;
        num_on = 1'b0;
        num    = '0;
        case (r_phase)
            PH_WALK: begin
                walk = 1'b1;
                hand = 1'b0;
            end
            PH_FLASH: begin
                hand   = w_el[0];
                num_on = 1'b1;
                num    = NUM_W'(HALF_FL) - NUM_W'(w_el >> 1);
            end
            default: ;
        endcase
    end

    assign req_pend = r_pend;
    assign phase    = r_phase;

endmodule

// File: tb/tb_cwalk_ctrl.sv
// Bench for cwalk_ctrl: a remaining-ticks reference model feeds a per-cycle
// scoreboard, plus a timeline table and hand-written corner-case sequences.
module tb_cwalk_ctrl;

    localparam int unsigned WALK_T  = 8;
    localparam int unsigned FLASH_T = 16;
    localparam int unsigned DONT_T  = 16;
    localparam int unsigned NUM_W   = 4;
    localparam int unsigned CNT_W   = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             tick = 1'b0;
    logic             recall = 1'b0;
    logic             ped_req = 1'b0;
    logic             walk;
    logic             hand;
    logic             num_on;
    logic [NUM_W-1:0] num;
    logic             req_pend;
    logic [1:0]       phase;

    always #5 clk = ~clk;

    cwalk_ctrl #(
        .WALK_T  (WALK_T),
        .FLASH_T (FLASH_T),
        .DONT_T  (DONT_T),
        .NUM_W   (NUM_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .recall   (recall),
        .ped_req  (ped_req),
        .walk     (walk),
        .hand     (hand),
        .num_on   (num_on),
        .num      (num),
        .req_pend (req_pend),
        .phase    (phase)
    );

    typedef struct packed {
        logic             w;
        logic             h;
        logic             no;
        logic [NUM_W-1:0] n;
        logic             p;
        logic [1:0]       ph;
    } obs_t;

    typedef struct {
        int               n;
        logic             t;
        logic             rc;
        logic             pr;
        logic [1:0]       ph;
        logic             w;
        logic             h;
        logic             no;
        logic [NUM_W-1:0] nm;
    } vec_t;

    obs_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    // Model: phase (0 DONT, 1 WALK, 2 FLASH), ticks remaining, pending flag.
    int   m_phase = 0;
    int   m_rem = DONT_T;
    logic m_pend = 1'b0;

    task automatic model_edge(input logic r, input logic t, input logic rc, input logic pr);
        int   old;
        logic go;
        logic entering;
        old      = m_phase;
        go       = rc | m_pend | pr;
        entering = 1'b0;
        if (r) begin
            m_phase = 0;
            m_rem   = DONT_T;
            m_pend  = 1'b0;
            return;
        end
        if (t) begin
            if (m_rem > 1) begin
                m_rem = m_rem - 1;
            end else if (old == 1) begin
                m_phase = 2;
                m_rem   = FLASH_T;
            end else if (old == 2) begin
                m_phase = 0;
                m_rem   = DONT_T;
            end else if (go) begin
                m_phase  = 1;
                m_rem    = WALK_T;
                entering = 1'b1;
            end
        end
        if (entering) m_pend = 1'b0;
        else if (pr && old != 1) m_pend = 1'b1;
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.w  = (m_phase == 1);
        o.h  = (m_phase == 0) ? 1'b1 : (m_phase == 2) ? ((m_rem % 2) == 1) : 1'b0;
        o.no = (m_phase == 2);
        o.n  = (m_phase == 2) ? NUM_W'((m_rem + 1) / 2) : '0;
        o.p  = m_pend;
        o.ph = 2'(m_phase);
        return o;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model, then compare after the edge.
    task automatic step(input logic r, input logic t, input logic rc, input logic pr);
        obs_t exp;
        obs_t act;
        reset   = r;
        tick    = t;
        recall  = rc;
        ped_req = pr;
        model_edge(r, t, rc, pr);
        sb_q.push_back(model_obs());
        @(posedge clk);
        #1;
        cyc++;
        act = '{w: walk, h: hand, no: num_on, n: num, p: req_pend, ph: phase};
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_empty cyc=%0d", cyc);
        end else begin
            exp = sb_q.pop_front();
            if (act !== exp) begin
                errors++;
                $display("FAIL sb cyc=%0d got w%b h%b no%b n%0d p%b ph%0d expected w%b h%b no%b n%0d p%b ph%0d",
                         cyc, act.w, act.h, act.no, act.n, act.p, act.ph,
                         exp.w, exp.h, exp.no, exp.n, exp.p, exp.ph);
            end
        end
    endtask

    task automatic do_reset();
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst.walk", int'(walk), 0);
        chk("rst.hand", int'(hand), 1);
        chk("rst.num_on", int'(num_on), 0);
        chk("rst.num", int'(num), 0);
        chk("rst.pend", int'(req_pend), 0);
        chk("rst.phase", int'(phase), 0);
        reset = 1'b0;
        cyc   = 0;
    endtask

    vec_t vecs[11];

    initial begin
        int bad;
        int w0, f0, d0, w1, nc0, nc1;
        logic [1:0]       prev_ph;
        logic [NUM_W-1:0] prev_num;

        vecs[0]  = '{15, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'd0};
        vecs[1]  = '{1,  1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 4'd0};
        vecs[2]  = '{7,  1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 4'd0};
        vecs[3]  = '{1,  1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 4'd8};
        vecs[4]  = '{1,  1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b1, 4'd8};
        vecs[5]  = '{1,  1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 4'd7};
        vecs[6]  = '{5,  1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b1, 4'd5};
        vecs[7]  = '{8,  1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b1, 4'd1};
        vecs[8]  = '{1,  1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'd0};
        vecs[9]  = '{15, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'd0};
        vecs[10] = '{1,  1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 4'd0};

        // Default recall run against the fixed timeline.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            for (int k = 0; k < vecs[i].n; k++) step(1'b0, vecs[i].t, vecs[i].rc, vecs[i].pr);
            chk($sformatf("vec%0d.phase", i), int'(phase), int'(vecs[i].ph));
            chk($sformatf("vec%0d.walk", i), int'(walk), int'(vecs[i].w));
            chk($sformatf("vec%0d.hand", i), int'(hand), int'(vecs[i].h));
            chk($sformatf("vec%0d.num_on", i), int'(num_on), int'(vecs[i].no));
            chk($sformatf("vec%0d.num", i), int'(num), int'(vecs[i].nm));
        end

        // On-demand: idle, then a request on a non-tick cycle is latched and served.
        do_reset();
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            if (phase != 2'd0 || hand != 1'b1) bad++;
        end
        chk("idle.not_dont", bad, 0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("req.pend101", int'(req_pend), 1);
        chk("req.walk101", int'(walk), 0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("req.walk102", int'(walk), 1);
        chk("req.pend102", int'(req_pend), 0);
        // Request on the exit tick goes straight to WALK without latching.
        for (int k = 0; k < 50; k++) step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("wait.phase", int'(phase), 0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("direct.walk", int'(walk), 1);
        chk("direct.pend", int'(req_pend), 0);

        // Request early in clearance waits for the full DONT_T.
        do_reset();
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("early.pend", int'(req_pend), 1);
        for (int k = 0; k < 9; k++) step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("early.ph15", int'(phase), 0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("early.ph16", int'(phase), 1);
        chk("early.pend16", int'(req_pend), 0);

        // Tick every third cycle stretches every phase by 3.
        do_reset();
        w0 = -1; f0 = -1; d0 = -1; w1 = -1; nc0 = -1; nc1 = -1;
        prev_ph  = phase;
        prev_num = num;
        for (int k = 0; k < 200; k++) begin
            step(1'b0, ((cyc % 3) == 0), 1'b1, 1'b0);
            if (phase != prev_ph) begin
                if (phase == 2'd1 && w0 < 0) w0 = cyc;
                else if (phase == 2'd2 && w0 >= 0 && f0 < 0) f0 = cyc;
                else if (phase == 2'd0 && f0 >= 0 && d0 < 0) d0 = cyc;
                else if (phase == 2'd1 && d0 >= 0 && w1 < 0) w1 = cyc;
            end
            if (phase == 2'd2 && prev_ph == 2'd2 && num != prev_num) begin
                if (nc0 < 0) nc0 = cyc;
                else if (nc1 < 0) nc1 = cyc;
            end
            prev_ph  = phase;
            prev_num = num;
        end
        chk("slow.walk_len", f0 - w0, 3 * WALK_T);
        chk("slow.flash_len", d0 - f0, 3 * FLASH_T);
        chk("slow.dont_len", w1 - d0, 3 * DONT_T);
        chk("slow.num_step", nc1 - nc0, 6);

        // Reset mid-FLASH aborts to DONT and restarts the full clearance.
        do_reset();
        for (int k = 0; k < 31; k++) step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("abort.num31", int'(num), 5);
        chk("abort.ph31", int'(phase), 2);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("abort.ph", int'(phase), 0);
        chk("abort.hand", int'(hand), 1);
        chk("abort.num_on", int'(num_on), 0);
        for (int k = 0; k < 15; k++) step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("abort.ph47", int'(phase), 0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("abort.walk48", int'(walk), 1);

        // ped_req held through WALK is ignored; no later WALK without a new request.
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 15; k++) step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("hold.walk", int'(walk), 1);
        bad = 0;
        while (m_phase == 1 && bad < 100) begin
            step(1'b0, 1'b1, 1'b0, 1'b1);
            if (req_pend != 1'b0) bad = bad + 1000;
            bad++;
        end
        chk("hold.pend_set", (bad >= 1000) ? 1 : 0, 0);
        bad = 0;
        for (int k = 0; k < 80; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            if (walk || req_pend) bad++;
        end
        chk("hold.no_rewalk", bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
